tu_chain_sequencer: RTL

Sequences a chain of simulation test units: launches each unit in order, waits for its completion handshake, records its pass/fail result and hands control to the next unit. It replaces the static, hard-tied pass token at the head of a test-unit chain with a controlled scheduler. It sits in the simulation top beside the RTL under test and reports an aggregate verdict once every unit has run.

---
 rtl/tu_seq_pkg.sv | 23 ++
 rtl/tu_seq_watchdog.sv | 39 +++
 rtl/tu_chain_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tu_seq_pkg.sv
// tu_seq_pkg: shared types and constants for the test-unit chain sequencer.
//   seq_state_e     - sequencer FSM state encoding
//   MAX_UNITS       - largest supported chain length
//   DEFAULT_TIMEOUT - default per-unit watchdog limit in clock cycles
//   idx_width()     - index width for a chain of n units (never below 1)
package tu_seq_pkg;

    localparam int unsigned MAX_UNITS       = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } seq_state_e;

    // Width of an index over n units; a single-unit chain still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tu_seq_watchdog.sv
// tu_seq_watchdog: per-unit watchdog for the test-unit chain sequencer.
// Present only when TU_SEQ_WATCHDOG_EN is defined.
//   clock   - system clock
//   rst     - synchronous, active-high reset
//   clear   - restart the count (asserted while a unit is being launched)
//   enable  - count this cycle (asserted while waiting on a unit)
//   expired - high during the TIMEOUT_CYCLES-th enabled cycle; the owner
//             times the unit out at the end of that cycle
`ifdef TU_SEQ_WATCHDOG_EN
module tu_seq_watchdog
    import tu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // expired is registered one count early so that it is visible during the
    // last permitted wait cycle without a combinational compare on the output.
    always_ff @(posedge clock) begin
        if (rst || clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (enable) begin
            count   <= count + CNT_W'(1);
            expired <= (count == CNT_W'(TIMEOUT_CYCLES - 2));
        end
    end

endmodule
`endif

// File: rtl/tu_chain_sequencer.sv
// tu_chain_sequencer: launches a chain of simulation test units one at a
// time, waits for each completion handshake, records pass/fail and reports
// an aggregate verdict when the chain ends.
//   clock        - system clock, rising edge
//   rst          - synchronous, active-high reset
//   start        - begin a sequence (sampled only when idle)
//   unit_start   - one-hot, one-cycle launch pulse per unit
//   unit_done    - per-unit completion strobe
//   unit_pass    - per-unit verdict, valid with unit_done
//   busy         - sequence in progress (through the done cycle)
//   done         - one-cycle end-of-sequence pulse
//   all_pass     - every unit ran and passed; valid from done onward
//   fail_mask    - units that failed or timed out
//   run_mask     - units that were launched
//   timeout_mask - units that timed out
//   cur_unit     - index of the active unit; holds after the sequence ends
// Optional feature: define TU_SEQ_WATCHDOG_EN to enable the per-unit
// watchdog. Without it a unit may wait forever and timeout_mask reads 0.
module tu_chain_sequencer
    import tu_seq_pkg::*;
#(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter bit          STOP_ON_FAIL   = 1'b0
) (
    input  logic                                clock,
    input  logic                                rst,
    input  logic                                start,
    output logic [NUM_UNITS-1:0]                unit_start,
    input  logic [NUM_UNITS-1:0]                unit_done,
    input  logic [NUM_UNITS-1:0]                unit_pass,
    output logic                                busy,
    output logic                                done,
    output logic                                all_pass,
    output logic [NUM_UNITS-1:0]                fail_mask,
    output logic [NUM_UNITS-1:0]                run_mask,
    output logic [NUM_UNITS-1:0]                timeout_mask,
    output logic [idx_width(NUM_UNITS)-1:0]     cur_unit
);

    localparam int unsigned          CUR_W     = idx_width(NUM_UNITS);
    localparam logic [CUR_W-1:0]     LAST_UNIT = CUR_W'(NUM_UNITS - 1);

    if (NUM_UNITS < 1 || NUM_UNITS > MAX_UNITS || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("tu_chain_sequencer: parameter out of range");
    end

    seq_state_e           state;
    logic                 wd_expired;
    logic [NUM_UNITS-1:0] cur_bit;
    logic [NUM_UNITS-1:0] fail_next;
    logic                 done_hit;
    logic                 time_out;
    logic                 unit_failed;
    logic                 finish_now;

`ifdef TU_SEQ_WATCHDOG_EN
    tu_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .rst     (rst),
        .clear   (state == LAUNCH),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );
`else
    assign wd_expired   = 1'b0;
    assign timeout_mask = '0;
`endif

    // Verdict for the active unit; only its own strobe counts, and a done
    // arriving on the watchdog's final cycle takes precedence over the timeout.
    always_comb begin
        cur_bit           = '0;
        cur_bit[cur_unit] = 1'b1;
        done_hit          = (state == WAIT) && unit_done[cur_unit];
        time_out          = (state == WAIT) && wd_expired && !done_hit;
        unit_failed       = time_out || (done_hit && !unit_pass[cur_unit]);
        fail_next         = unit_failed ? (fail_mask | cur_bit) : fail_mask;
        finish_now        = (cur_unit == LAST_UNIT) || (STOP_ON_FAIL && unit_failed);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state        <= IDLE;
            unit_start   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            all_pass     <= 1'b0;
            fail_mask    <= '0;
            run_mask     <= '0;
`ifdef TU_SEQ_WATCHDOG_EN
            timeout_mask <= '0;
`endif
            cur_unit     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fail_mask    <= '0;
                        run_mask     <= '0;
`ifdef TU_SEQ_WATCHDOG_EN
                        timeout_mask <= '0;
`endif
                        all_pass     <= 1'b0;
                        cur_unit     <= '0;
                        unit_start   <= NUM_UNITS'(1);
                        busy         <= 1'b1;
                        state        <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    unit_start <= '0;
                    run_mask   <= run_mask | cur_bit;
                    state      <= WAIT;
                end

                WAIT: begin
                    if (done_hit || time_out) begin
                        fail_mask <= fail_next;
`ifdef TU_SEQ_WATCHDOG_EN
                        if (time_out) begin
                            timeout_mask <= timeout_mask | cur_bit;
                        end
`endif
                        if (finish_now) begin
                            done     <= 1'b1;
                            // run_mask already includes the active unit.
                            all_pass <= (fail_next == '0) && (run_mask == '1);
                            state    <= FINISH;
                        end else begin
                            cur_unit   <= cur_unit + CUR_W'(1);
                            unit_start <= cur_bit << 1;
                            state      <= LAUNCH;
                        end
                    end
                end

                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
